// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input registered multiplexer with valid/ready handshaking.
// Define MUX_ARB_RR_EN to compile in round-robin arbitration (selected by rr_mode); otherwise fixed select only.
module mux_arb_n #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               rr_mode,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_grant,
    output logic               out_valid,
    input  logic               out_ready
);

    genvar gi, gb;

    logic                    load_ok;
    logic                    req_hit;
    logic                    transfer;
    logic [N-1:0]            sel_hit;
    logic [N-1:0]            grant_onehot;
    logic [SELW-1:0]         grant_idx;
    logic [WIDTH-1:0][N-1:0] data_bits;
    logic [WIDTH-1:0]        data_sel;

    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic [SELW-1:0]         out_grant_q, out_grant_d;

    // The register can take a new word when empty or being drained this cycle.
    assign load_ok = !out_valid_q || out_ready;

    // A select value >= N matches no channel, so it can never produce a transfer.
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            assign sel_hit[gi] = (sel == SELW'(gi));
        end
    endgenerate

`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0]         last_grant_q, last_grant_d;
    logic [SELW-1:0]         rr_start;
    logic [SELW-1:0]         rr_idx;
    logic [N-1:0]            hi_req;
    logic [N-1:0]            hi_pick;
    logic [N-1:0]            lo_pick;
    logic [N-1:0]            rr_onehot;
    logic                    hi_any;
    logic [SELW-1:0][N-1:0]  idx_bits;

    assign rr_start = (last_grant_q == SELW'(N-1)) ? '0 : last_grant_q + SELW'(1);
    assign hi_any   = |hi_req;

    // Circular search as two linear passes: requests at or above the start
    // index win first; otherwise the lowest requester below it wraps around.
    generate
        for (gi = 0; gi < N; gi++) begin : g_rr
            localparam logic [N-1:0] BELOW = (N'(1) << gi) - N'(1);
            assign hi_req[gi]    = in_valid[gi] && (SELW'(gi) >= rr_start);
            assign hi_pick[gi]   = hi_req[gi] && ((hi_req & BELOW) == '0);
            assign lo_pick[gi]   = in_valid[gi] && ((in_valid & BELOW) == '0);
            assign rr_onehot[gi] = hi_any ? hi_pick[gi] : lo_pick[gi];
        end

        for (gb = 0; gb < SELW; gb++) begin : g_rr_idx
            for (gi = 0; gi < N; gi++) begin : g_bit
                assign idx_bits[gb][gi] = rr_onehot[gi] && (((gi >> gb) & 1) == 1);
            end
            assign rr_idx[gb] = |idx_bits[gb];
        end
    endgenerate

    assign grant_onehot = rr_mode ? rr_onehot : sel_hit;
    assign grant_idx    = rr_mode ? rr_idx : sel;
    assign req_hit      = rr_mode ? (|in_valid) : (|(sel_hit & in_valid));

    // The pointer only moves on round-robin transfers; fixed-mode traffic leaves it alone.
    assign last_grant_d = (transfer && rr_mode) ? rr_idx : last_grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SELW'(N-1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    logic unused_rr_mode;
    assign unused_rr_mode = rr_mode;

    assign grant_onehot = sel_hit;
    assign grant_idx    = sel;
    assign req_hit      = |(sel_hit & in_valid);
`endif

    assign transfer = rst_n && load_ok && req_hit;
    assign in_ready = transfer ? grant_onehot : '0;

    // AND-OR mux keyed by the one-hot accept vector.
    generate
        for (gb = 0; gb < WIDTH; gb++) begin : g_dmux
            for (gi = 0; gi < N; gi++) begin : g_chan
                assign data_bits[gb][gi] = in_ready[gi] && in_data[gi*WIDTH + gb];
            end
            assign data_sel[gb] = |data_bits[gb];
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel;
            out_grant_d = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grant = out_grant_q;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));
    a_grant_range:  assert property (@(posedge clk) rst_n |-> (out_grant_q <= SELW'(N-1)));
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Randomised scoreboard bench for mux_arb_n (N=4 main instance plus a small N=3 instance).
// Round-robin checks are compiled only when MUX_ARB_RR_EN is defined, matching the RTL build.
module tb_mux_arb_n;
    localparam int W = 16;
    localparam int N = 4;
`ifdef MUX_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main N=4 instance
    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [1:0]    sel;
    logic          rr_mode;
    logic [W-1:0]  out_data;
    logic [1:0]    out_grant;
    logic          out_valid;
    logic          out_ready;

    mux_arb_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
        .out_grant(out_grant), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Small N=3 instance for non-power-of-two wrap behaviour
    logic        rst3_n;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        rr3;
    logic [7:0]  out_data3;
    logic [1:0]  out_grant3;
    logic        out_valid3;
    logic        out_ready3;

    mux_arb_n #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .rr_mode(rr3), .out_data(out_data3),
        .out_grant(out_grant3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   grant;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_m = N - 1;
    bit   xfer_now = 1'b0;
    bit   rst_now = 1'b0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle of stimulus and work out the expected handshake from the rules.
    task automatic drive(input logic rst, input logic [3:0] v, input logic [63:0] d,
                         input logic [1:0] s, input logic rr, input logic ordy);
        bit   found;
        int   g;
        int   idx;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = v;
        in_data   = d;
        sel       = s;
        rr_mode   = rr;
        out_ready = ordy;
        #1;
        exp_rdy  = 4'b0000;
        xfer_now = 1'b0;
        rst_now  = !rst;
        found    = 1'b0;
        g        = 0;
        if (rst) begin
            if (RR_EN && rr) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (last_m + k) % N;
                    if (!found && v[2'(idx)]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
            end else begin
                found = v[s];
                g     = int'(s);
            end
            if ((q.size() == 0 || ordy) && found) begin
                exp_rdy[2'(g)] = 1'b1;
                xfer_now = 1'b1;
                q.push_back('{d[g*W +: W], 2'(g)});
                if (RR_EN && rr) last_m = g;
            end
        end else begin
            last_m = N - 1;
        end
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    endtask

    // Monitor: compares the presented word with the scoreboard and retires it on acceptance.
    initial begin
        int held;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                held = q.size() - (xfer_now ? 1 : 0);
                chk("out_valid", 64'(out_valid), 64'(held > 0));
                if (out_valid && held > 0) begin
                    chk("out_data", 64'(out_data), 64'(q[0].data));
                    chk("out_grant", 64'(out_grant), 64'(q[0].grant));
                    if (out_ready) begin
                        $display("word grant=%0d data=0x%04h", out_grant, out_data);
                        void'(q.pop_front());
                    end
                end
                if (rst_now) q.delete();
            end
        end
    end

    task automatic tick3(input logic rst, input logic [2:0] v, input logic [1:0] s,
                         input logic rr, input logic ordy);
        @(negedge clk);
        rst3_n     = rst;
        in_valid3  = v;
        sel3       = s;
        rr3        = rr;
        out_ready3 = ordy;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic [63:0] d_hold;
        logic [3:0]  exp_g [12];

        rst_n = 1'b0; in_valid = '0; in_data = '0; sel = '0; rr_mode = 1'b0; out_ready = 1'b0;
        rst3_n = 1'b0; in_valid3 = '0; in_data3 = 24'h33_22_11; sel3 = '0; rr3 = 1'b0; out_ready3 = 1'b1;

        // Reset with every request active: nothing may be accepted
        drive(1'b0, 4'b1111, rand_data(), 2'd0, 1'b1, 1'b1);
        mon_en = 1'b1;
        drive(1'b0, 4'b1111, rand_data(), 2'd1, 1'b0, 1'b1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_grant", 64'(out_grant), 64'd0);

        // Fixed select of channel 2
        d = 64'd0;
        d[47:32] = 16'hBEEF;
        drive(1'b1, 4'b0100, d, 2'd2, 1'b0, 1'b1);
        chk("fix_ready", 64'(in_ready), 64'b0100);
        drive(1'b1, 4'b0111, rand_data(), 2'd3, 1'b0, 1'b1);
        chk("fix_valid", 64'(out_valid), 64'd1);
        chk("fix_data", 64'(out_data), 64'hBEEF);
        chk("fix_grant", 64'(out_grant), 64'd2);
        chk("fix_noreq_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 4'b0000, rand_data(), 2'd3, 1'b0, 1'b1);
        chk("fix_drain", 64'(out_valid), 64'd0);

        // Backpressure then simultaneous pop and load
        d_hold = rand_data();
        drive(1'b1, 4'b1111, d_hold, 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1111, rand_data(), 2'd0, 1'b0, 1'b0);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_data", 64'(out_data), 64'(d_hold[31:16]));
        end
        d = rand_data();
        drive(1'b1, 4'b1111, d, 2'd0, 1'b0, 1'b1);
        chk("bp_release_ready", 64'(in_ready), 64'b0001);
        drive(1'b1, 4'b0000, rand_data(), 2'd0, 1'b0, 1'b1);
        chk("bp_nobubble_valid", 64'(out_valid), 64'd1);
        chk("bp_nobubble_data", 64'(out_data), 64'(d[15:0]));

`ifdef MUX_ARB_RR_EN
        // Round-robin fairness: all requesting, then alternate pair
        drive(1'b0, 4'b0000, rand_data(), 2'd0, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) exp_g[k] = (k < 8) ? 4'(k % 4) : ((k % 2 == 0) ? 4'd1 : 4'd3);
        for (int k = 0; k <= 12; k++) begin
            drive(1'b1, (k < 8) ? 4'b1111 : ((k < 12) ? 4'b1010 : 4'b0000),
                  rand_data(), 2'(k), 1'b1, 1'b1);
            if (k > 0) chk("rr_grant_seq", 64'(out_grant), 64'(exp_g[k-1]));
        end

        // Reset mid-stream with a held word and last_grant=1
        drive(1'b1, 4'b0010, rand_data(), 2'd3, 1'b1, 1'b1);
        drive(1'b1, 4'b0000, rand_data(), 2'd3, 1'b1, 1'b0);
        chk("rr_pre_rst_grant", 64'(out_grant), 64'd1);
        drive(1'b0, 4'b1111, rand_data(), 2'd3, 1'b1, 1'b1);
        drive(1'b1, 4'b1111, rand_data(), 2'd3, 1'b1, 1'b1);
        chk("rr_post_rst_valid", 64'(out_valid), 64'd0);
        chk("rr_post_rst_ready", 64'(in_ready), 64'b0001);
        drive(1'b1, 4'b0000, rand_data(), 2'd3, 1'b1, 1'b1);
        chk("rr_post_rst_grant", 64'(out_grant), 64'd0);
`endif

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 64) != 0, 4'($urandom), rand_data(), 2'($urandom),
                  1'($urandom), ($urandom % 4) != 0);
        end

        for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, rand_data(), 2'd0, 1'b0, 1'b1);
        #2;
        chk("drain_empty", 64'(q.size()), 64'd0);

        // N=3 instance: out-of-range select and non-power-of-two wrap
        tick3(1'b0, 3'b111, 2'd0, 1'b0, 1'b1);
        tick3(1'b1, 3'b111, 2'd3, 1'b0, 1'b1);
        chk("n3_sel_oob_ready", 64'(in_ready3), 64'd0);
        tick3(1'b1, 3'b111, 2'd2, 1'b0, 1'b1);
        chk("n3_fix_ready", 64'(in_ready3), 64'b100);
        tick3(1'b1, 3'b000, 2'd2, 1'b0, 1'b1);
        chk("n3_fix_data", 64'(out_data3), 64'h33);
        chk("n3_fix_grant", 64'(out_grant3), 64'd2);
`ifdef MUX_ARB_RR_EN
        tick3(1'b0, 3'b000, 2'd0, 1'b1, 1'b1);
        tick3(1'b1, 3'b100, 2'd0, 1'b1, 1'b1);
        chk("n3_rr_first", 64'(in_ready3), 64'b100);
        tick3(1'b1, 3'b011, 2'd0, 1'b1, 1'b1);
        chk("n3_rr_wrap", 64'(in_ready3), 64'b001);
        tick3(1'b1, 3'b001, 2'd1, 1'b1, 1'b1);
        chk("n3_rr_sparse", 64'(in_ready3), 64'b001);
        tick3(1'b1, 3'b000, 2'd1, 1'b1, 1'b1);
        chk("n3_rr_grant", 64'(out_grant3), 64'd0);
        chk("n3_rr_data", 64'(out_data3), 64'h11);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-input registered multiplexer with valid/ready handshaking and optional round-robin arbitration. It is the next generation of the team's 16-bit 2:1 datapath mux. Width and channel count are generalised, and a one-entry output register sits between producers (register file ports, ALU/memory result sources) and a single downstream consumer. The register decouples selection timing from the consumer.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- N, 4, number of input channels (≥2)
- SELW, $clog2(N), width of select/grant fields (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; synchronous and active-low
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel request
- in_ready  output  N  per-channel accept, one-hot or zero
- sel  input  SELW  channel select, used in fixed mode
- rr_mode  input  1  1 = round-robin arbitration, 0 = fixed select
- out_data  output  WIDTH  registered selected data
- out_grant  output  SELW  index of channel held in output register
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data

## Operation
- Output register state: out_data, out_grant, out_valid. Round-robin pointer: last_grant (SELW bits).
- The register may load when `load_ok = !out_valid || out_ready`.
- Fixed mode (rr_mode=0, or macro absent):
  - grant = sel.
  - A transfer occurs when load_ok && in_valid[sel].
  - sel ≥ N produces no transfer and all in_ready are 0.
- Round-robin mode (rr_mode=1):
  - grant is the first i with in_valid[i]=1, searching circularly from (last_grant+1) mod N.
  - A transfer occurs when load_ok && any in_valid.
  - On each transfer, last_grant ← grant.
  - last_grant is unchanged when there is no transfer.
  - sel is ignored.
- in_ready[i] = transfer && (grant == i). It is combinational, depends on out_ready, and at most one bit is set.
- On transfer, at the next edge: out_data ← in_data[grant], out_grant ← grant, out_valid ← 1.
- On out_valid && out_ready with no transfer: out_valid ← 0. out_data and out_grant hold their last values.
- If out_valid && !out_ready, the register holds and every in_ready is 0 (backpressure).
- Switching rr_mode takes effect in the same cycle. last_grant is retained across mode switches but is updated only by round-robin transfers.

## Timing
- Latency: 1 cycle from the in_valid/in_ready handshake to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- A consumer pop and a producer load on the same edge replace the register contents with no bubble.
- Reset (rst_n=0 at an edge):
  - out_valid=0, out_data=0, out_grant=0, last_grant=N-1, so the first round-robin search starts at channel 0.
  - in_ready=0 for every cycle in which rst_n is low.
- Reset mid-operation discards held data. No handshake completes in a reset cycle.
- Wrap-around: with last_grant = N-1, the search starts at 0.
- Non-power-of-two N: the circular search uses mod N. Indices ≥ N are never granted.
- Inputs must be stable only at the clock edge. There is no combinational path from in_valid to out_valid.

## Configuration
- MUX_ARB_RR_EN defined:
  - Round-robin logic and the last_grant register are compiled in.
  - rr_mode behaves as above.
- MUX_ARB_RR_EN undefined:
  - The block is fixed-select only.
  - rr_mode is ignored (port retained for interface compatibility).
  - last_grant is not implemented.
  - Behaviour is identical to rr_mode=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 and out_ready=1 → out_valid=0, out_data=0, out_grant=0, in_ready=0 throughout.
- Fixed select, WIDTH=16, N=4, rr_mode=0, sel=2, in_data[2]=16'hBEEF, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100 in that cycle; next cycle out_valid=1, out_data=16'hBEEF, out_grant=2. Then sel=3 with in_valid[3]=0 → no transfer, out_valid=0 the following cycle.
- Backpressure: out_valid=1, out_ready=0, in_valid=4'b1111 for 3 cycles → in_ready=0 and out_data unchanged. Raise out_ready → pop and new load on the same edge, no idle cycle.
- Round-robin fairness (macro defined): rr_mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles → out_grant sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 → grants alternate 1,3,1,3.
- Wrap and sparse requests, N=3: after grant 2, in_valid=3'b011 → grant 0. After grant 0, in_valid=3'b001 → grant 0 again.
- Reset mid-stream during round-robin at last_grant=1 → after reset, with in_valid=4'b1111, first grant=0 and the previously held out_data is not presented.
